alu_op_sequencer: RTL

//  Drives the 16-bit ripple ALU's control lines (ainvert, bnegate, cin, op) and consumes its result/flags.

---
 rtl/alu_op_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sequences one command through an external combinational 16-bit ALU.
//   A command is accepted over req_valid/req_ready, its function code is
//   decoded into the ALU control lines, and the ALU is run once (16-bit op)
//   or twice, low half then high half with the carry chained (32-bit op).
//   The assembled result and flags are returned over rsp_valid/rsp_ready.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         command handshake
//   req_func, req_wide          function code, 32-bit select
//   req_a, req_b                32-bit operands
//   alu_a, alu_b                registered operand halves to the ALU
//   alu_cin/ainvert/bnegate/op  registered ALU controls
//   alu_result/cout/overflow    ALU outputs, sampled on the last settle cycle
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero        32-bit result, result==0
//   rsp_cout, rsp_overflow      flags of the final pass
//   rsp_err                     illegal function code
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_func,
  input  logic        req_wide,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_ainvert,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_cout,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_SLT = 4'b0111;
  localparam logic [3:0] F_NOR = 4'b1100;

  // Counter counts down to zero; zero marks the last cycle of a pass.
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  // arith: the high pass takes its carry-in from the low pass carry-out.
  typedef struct packed {
    logic       legal;
    logic       ainvert;
    logic       bnegate;
    logic [2:0] op;
    logic       cin_lo;
    logic       arith;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [3:0] func);
    ctrl_t c;
    c = '0;
    // Field order: legal, ainvert, bnegate, op, cin_lo, arith
    unique case (func)
      F_AND:   c = '{1'b1, 1'b0, 1'b0, OP_AND, 1'b0, 1'b0};
      F_OR:    c = '{1'b1, 1'b0, 1'b0, OP_OR,  1'b0, 1'b0};
      F_ADD:   c = '{1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b1};
      F_SUB:   c = '{1'b1, 1'b0, 1'b1, OP_ADD, 1'b1, 1'b1};
      F_SLT:   c = '{1'b1, 1'b0, 1'b1, OP_SLT, 1'b1, 1'b1};
      F_NOR:   c = '{1'b1, 1'b1, 1'b1, OP_AND, 1'b0, 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  func_q;
  logic        wide_q;
  logic [31:0] a_q, b_q;
  logic [15:0] lo_result_q, lo_result_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        alu_cin_q, alu_cin_d, alu_ainv_q, alu_ainv_d, alu_bneg_q, alu_bneg_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d, rsp_cout_q, rsp_cout_d;
  logic        rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;

  logic        accept, pass_done, src_wide;
  logic [3:0]  src_func;
  logic [31:0] src_a, src_b, wide_result;
  ctrl_t       ctrl;

  // In IDLE the LO-pass drive is built straight from the request so the ALU
  // inputs are already valid in the first cycle after the accept edge.
  assign src_func    = (state_q == S_IDLE) ? req_func : func_q;
  assign src_wide    = (state_q == S_IDLE) ? req_wide : wide_q;
  assign src_a       = (state_q == S_IDLE) ? req_a    : a_q;
  assign src_b       = (state_q == S_IDLE) ? req_b    : b_q;
  assign ctrl        = decode(src_func);
  assign accept      = req_valid && (state_q == S_IDLE);
  assign pass_done   = (cnt_q == 4'd0);
  assign wide_result = (func_q == F_SLT) ? {31'h0, alu_result[0]} : {alu_result, lo_result_q};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    lo_result_d  = lo_result_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ctrl.legal) begin
            state_d = S_LO;
            cnt_d   = CNT_RELOAD;
          end else begin
            // Illegal code skips the ALU entirely; every flag is cleared.
            state_d      = S_RESP;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_cout_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
          end
        end
      end
      S_LO: begin
        if (!pass_done) begin
          cnt_d = cnt_q - 4'd1;
        end else if (wide_q) begin
          state_d     = S_HI;
          cnt_d       = CNT_RELOAD;
          lo_result_d = alu_result;
        end else begin
          state_d      = S_RESP;
          rsp_result_d = {16'h0, alu_result};
          rsp_zero_d   = (alu_result == 16'h0);
          rsp_cout_d   = alu_cout;
          rsp_ovf_d    = alu_overflow;
          rsp_err_d    = 1'b0;
        end
      end
      S_HI: begin
        if (!pass_done) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = S_RESP;
          rsp_result_d = wide_result;
          rsp_zero_d   = (wide_result == 32'h0);
          rsp_cout_d   = alu_cout;
          rsp_ovf_d    = alu_overflow;
          rsp_err_d    = 1'b0;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive is registered, so it is computed from the state being entered.
  always_comb begin
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_cin_d  = 1'b0;
    alu_ainv_d = 1'b0;
    alu_bneg_d = 1'b0;
    alu_op_d   = OP_AND;
    unique case (state_d)
      S_LO: begin
        alu_a_d    = src_a[15:0];
        alu_b_d    = src_b[15:0];
        alu_ainv_d = ctrl.ainvert;
        alu_bneg_d = ctrl.bnegate;
        // Wide SLT only needs the borrow from the low half, so subtract there.
        alu_op_d   = (ctrl.op == OP_SLT && src_wide) ? OP_ADD : ctrl.op;
        alu_cin_d  = ctrl.cin_lo;
      end
      S_HI: begin
        alu_a_d    = a_q[31:16];
        alu_b_d    = b_q[31:16];
        alu_ainv_d = ctrl.ainvert;
        alu_bneg_d = ctrl.bnegate;
        alu_op_d   = ctrl.op;
        if (!ctrl.arith)            alu_cin_d = ctrl.cin_lo;
        else if (state_q == S_LO)   alu_cin_d = alu_cout;
        else                        alu_cin_d = alu_cin_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      func_q       <= '0;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      lo_result_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_ainv_q   <= 1'b0;
      alu_bneg_q   <= 1'b0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_result_q  <= lo_result_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      alu_ainv_q   <= alu_ainv_d;
      alu_bneg_q   <= alu_bneg_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      if (accept) begin
        func_q <= req_func;
        wide_q <= req_wide;
        a_q    <= req_a;
        b_q    <= req_b;
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cin      = alu_cin_q;
  assign alu_ainvert  = alu_ainv_q;
  assign alu_bnegate  = alu_bneg_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_err      = rsp_err_q;

endmodule
